// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_pkg
// Purpose : Shared types, Booth digit codes and size-derivation helpers for
//           the radix-4 Booth sequential multiplier.
// Contents: state_t       - controller states (IDLE, RUN, DONE)
//           ZERO..NEG2    - Booth digit codes
//           calc_w/k/iter - extended width, digit count, compute cycles
//           booth_encode  - maps a 3-bit Booth triple to a digit code
// Revision: 1.0 - initial release
// ============================================================================
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] POS1 = 3'd1;
  localparam logic [2:0] POS2 = 3'd2;
  localparam logic [2:0] NEG1 = 3'd3;
  localparam logic [2:0] NEG2 = 3'd4;

  // Extended operand width: N plus one or two guard bits, rounded to even so
  // the operand splits into whole radix-4 digits.
  function automatic int calc_w(input int n);
    return 2 * ((n + 2) / 2);
  endfunction

  function automatic int calc_k(input int n);
    return calc_w(n) / 2;
  endfunction

  function automatic int calc_iter(input int n, input int d);
    return (calc_k(n) + d - 1) / d;
  endfunction

  function automatic logic [2:0] booth_encode(input logic [2:0] triple);
    logic [2:0] code;
    case (triple)
      3'b001, 3'b010: code = POS1;
      3'b011:         code = POS2;
      3'b100:         code = NEG2;
      3'b101, 3'b110: code = NEG1;
      default:        code = ZERO;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_pp.sv
`default_nettype none
// ============================================================================
// Module  : booth_r4_pp
// Purpose : Combinational radix-4 Booth partial-product generator.
// Ports   : triple [2:0] in  - {b[2j+1], b[2j], b[2j-1]}
//           mcand  [W-1] in  - extended multiplicand (two's complement)
//           pp     [W:0] out - signed partial product in {0, +-A, +-2A}
// Revision: 1.0 - initial release
// ============================================================================
module booth_r4_pp
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   triple,
  input  logic [W-1:0] mcand,
  output logic [W:0]   pp
);

  logic [2:0] code;
  logic [W:0] pos_a;
  logic [W:0] neg_a;

  always_comb begin
    code  = booth_encode(triple);
    // One extra bit so that +-2A never overflows.
    pos_a = {mcand[W-1], mcand};
    neg_a = ~pos_a + {{W{1'b0}}, 1'b1};
    case (code)
      POS1:    pp = pos_a;
      POS2:    pp = pos_a << 1;
      NEG1:    pp = neg_a;
      NEG2:    pp = neg_a << 1;
      default: pp = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/radix4_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : radix4_booth_seq_mult
// Purpose : Iterative radix-4 Booth multiplier, D digits per cycle, with
//           valid/ready handshakes on input and output. sgn selects signed
//           or unsigned operands per transaction.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, op_a[N], op_b[N], sgn  - operand channel
//           out_valid/out_ready, product[2N]          - result channel
//           busy                                      - state != IDLE
// Revision: 1.0 - initial release
// ============================================================================
module radix4_booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int W    = calc_w(N);
  localparam int K    = calc_k(N);
  localparam int ITER = calc_iter(N, D);
  localparam int CNTW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t          state;
  state_t          state_next;
  logic            rst_done;
  logic [N-1:0]    op_a_q;
  logic            sgn_q;
  logic [W:0]      b_sh;      // multiplier with b[-1] appended, shifted 2D per cycle
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_sum;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    a_ext;
  logic            accept;
  logic            last;
  int              digit_base;
  logic [2*W-1:0]  contrib [D];

  assign in_ready   = (state == IDLE) && rst_done;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign last       = (cnt == CNTW'(ITER - 1));
  assign digit_base = int'(cnt) * D;
  assign a_ext      = {{(W-N){sgn_q & op_a_q[N-1]}}, op_a_q};

  // Each lane retires digit digit_base+l; lanes past the top digit are masked
  // because the shifted multiplier's fill bits would otherwise form a digit.
  for (genvar l = 0; l < D; l++) begin : g_lane
    logic [W:0]     pp;
    logic [2*W-1:0] pp_ext;

    booth_r4_pp #(.W(W)) u_pp (
      .triple (b_sh[2*l+2:2*l]),
      .mcand  (a_ext),
      .pp     (pp)
    );

    assign pp_ext     = {{(W-1){pp[W]}}, pp};
    assign contrib[l] = ((digit_base + l) < K) ? (pp_ext << (2 * (digit_base + l))) : '0;
  end

  always_comb begin
    acc_sum = acc;
    for (int l = 0; l < D; l++) begin
      acc_sum = acc_sum + contrib[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
      op_a_q   <= '0;
      sgn_q    <= 1'b0;
      b_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            op_a_q <= op_a;
            sgn_q  <= sgn;
            b_sh   <= {{(W-N){sgn & op_b[N-1]}}, op_b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc  <= acc_sum;
          b_sh <= b_sh >> (2 * D);
          cnt  <= cnt + CNTW'(1);
          if (last) begin
            product <= acc_sum[2*N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_radix4_booth_seq_mult
// Purpose : Self-checking bench for radix4_booth_seq_mult over several
//           (N, D) configurations, against an arithmetic reference product.
// Revision: 1.0 - initial release
// ============================================================================
module tb_radix4_booth_seq_mult;

  localparam int NCFG = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_n(input int g);
    return (g < 3) ? 8 : ((g < 6) ? 7 : 16);
  endfunction

  // Third entry of each group is D = K (one compute cycle).
  function automatic int cfg_d(input int g);
    int d;
    case (g)
      0: d = 1; 1: d = 2; 2: d = 5;
      3: d = 1; 4: d = 2; 5: d = 4;
      6: d = 1; 7: d = 2; default: d = 9;
    endcase
    return d;
  endfunction

  // Exact product modulo 2^(2n), operands interpreted per mode.
  function automatic logic [63:0] ref_mul(input int n, input logic [63:0] a,
                                          input logic [63:0] b, input logic s);
    longint sa;
    longint sb;
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    sa = longint'(a & mask);
    sb = longint'(b & mask);
    if (s && a[n-1]) sa = sa - (longint'(1) << n);
    if (s && b[n-1]) sb = sb - (longint'(1) << n);
    return 64'(sa * sb) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int TN    = cfg_n(g);
    localparam int TD    = cfg_d(g);
    localparam int TITER = ((TN + 2) / 2 + TD - 1) / TD;

    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [TN-1:0]   op_a;
    logic [TN-1:0]   op_b;
    logic            sgn;
    logic            out_valid;
    logic            out_ready;
    logic [2*TN-1:0] product;
    logic            busy;

    radix4_booth_seq_mult #(.N(TN), .D(TD)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sgn       (sgn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
    );

    function automatic string tg(input string s);
      return $sformatf("n%0d_d%0d_%s", TN, TD, s);
    endfunction

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_txn(input logic [TN-1:0] a, input logic [TN-1:0] b,
                           input logic s, input int bp, input bit inject);
      int          lat;
      logic [63:0] exp;
      exp = ref_mul(TN, 64'(a), 64'(b), s);
      lat = 0;
      while (!in_ready && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check(tg("in_ready"), 64'(in_ready), 64'd1);
      if (!in_ready) return;
      check(tg("no_spurious_ov"), 64'(out_valid), 64'd0);
      op_a = a; op_b = b; sgn = s; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; op_a = ~a; op_b = ~b; sgn = ~s;
      check(tg("busy"), 64'(busy), 64'd1);
      check(tg("ready_low"), 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check(tg("latency"), 64'(lat), 64'(TITER));
      check(tg("product"), 64'(product), exp);
      for (int i = 0; i < bp; i++) begin
        if (inject) begin
          in_valid = 1'b1; op_a = TN'($urandom); op_b = TN'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check(tg("hold_ov"), 64'(out_valid), 64'd1);
        check(tg("hold_prod"), 64'(product), exp);
        check(tg("hold_ready"), 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check(tg("ov_drop"), 64'(out_valid), 64'd0);
      check(tg("retain"), 64'(product), exp);
      check(tg("idle"), 64'(busy), 64'd0);
    endtask

    initial begin
      logic [TN-1:0] msb;
      logic [TN-1:0] ones;
      logic [TN-1:0] maxp;
      msb  = {1'b1, {(TN-1){1'b0}}};
      ones = '1;
      maxp = ~msb;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; sgn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check(tg("rst_ov"), 64'(out_valid), 64'd0);
      check(tg("rst_busy"), 64'(busy), 64'd0);
      check(tg("rst_prod"), 64'(product), 64'd0);
      check(tg("rst_ready"), 64'(in_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check(tg("post_rst_ready"), 64'(in_ready), 64'd1);

      // Boundary operands
      run_txn(msb,  msb,  1'b1, 0, 1'b0);
      run_txn(ones, ones, 1'b0, 2, 1'b1);
      run_txn(ones, ones, 1'b1, 0, 1'b0);
      run_txn(ones, maxp, 1'b1, 10, 1'b1);
      run_txn(maxp, maxp, 1'b0, 1, 1'b0);
      run_txn(msb,  maxp, 1'b1, 0, 1'b0);
      run_txn(msb,  ones, 1'b0, 0, 1'b0);
      run_txn('0,   ones, 1'b1, 0, 1'b0);

      // Reset in the middle of a computation
      op_a = TN'(8'h12); op_b = TN'(8'h34); sgn = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check(tg("abort_ov"), 64'(out_valid), 64'd0);
      check(tg("abort_busy"), 64'(busy), 64'd0);
      check(tg("abort_prod"), 64'(product), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(TN'(8'h12), TN'(8'h34), 1'b1, 0, 1'b0);

      // Random sweep with backpressure and ignored in_valid pulses
      for (int i = 0; i < 30; i++) begin
        run_txn(TN'($urandom), TN'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
      end
      done_cnt++;
    end
  end

  initial begin
    int k;
    k = 0;
    while (done_cnt < NCFG && k < 50000) begin
      @(posedge clk);
      k++;
    end
    check("all_done", 64'(done_cnt), 64'(NCFG));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
